// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the Y86-64 register file: serializes one E/M bundle
// per instruction onto the single write port and flags decode-stage RAW hazards.
module regfile_wb_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  dstE,
  input  logic [63:0] valE,
  input  logic [3:0]  dstM,
  input  logic [63:0] valM,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [63:0] wr_data,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output logic        stall,
  output logic [15:0] wr_count,
  output logic [0:0]  dbg_state
);

  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] HOLD_M = 1'b1;

  // Handshake: a bundle is consumed on a posedge where in_valid && in_ready;
  // while in_ready is low the producer keeps the bundle stable.
  logic [0:0]  state;
  logic [3:0]  park_addr;
  logic [63:0] park_data;
  logic        accept;
  logic        e_live;
  logic        m_live;
  logic        m_only;
  logic        hit_a;
  logic        hit_b;

  assign dbg_state = state;
  assign in_ready  = rst_n && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign e_live    = (dstE != RNONE);
  assign m_live    = (dstM != RNONE);
  // M wins when both target the same register (popq %rsp).
  assign m_only    = m_live && (!e_live || (dstE == dstM));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      park_addr <= RNONE;
      park_data <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= RNONE;
      wr_data   <= '0;
      wr_count  <= '0;
    end else begin
      if (wr_en) wr_count <= wr_count + 16'd1;
      wr_en   <= 1'b0;
      wr_addr <= RNONE;
      wr_data <= '0;
      if (state == HOLD_M) begin
        wr_en     <= 1'b1;
        wr_addr   <= park_addr;
        wr_data   <= park_data;
        park_addr <= RNONE;
        park_data <= '0;
        state     <= IDLE;
      end else if (accept) begin
        if (m_only) begin
          wr_en   <= 1'b1;
          wr_addr <= dstM;
          wr_data <= valM;
        end else if (e_live) begin
          wr_en   <= 1'b1;
          wr_addr <= dstE;
          wr_data <= valE;
          if (m_live) begin
            park_addr <= dstM;
            park_data <= valM;
            state     <= HOLD_M;
          end
        end
      end
    end
  end

  // Pending set: the register on the write port now plus any parked M write.
  assign hit_a = (srcA != RNONE) &&
                 ((wr_en && (wr_addr == srcA)) || ((state == HOLD_M) && (park_addr == srcA)));
  assign hit_b = (srcB != RNONE) &&
                 ((wr_en && (wr_addr == srcB)) || ((state == HOLD_M) && (park_addr == srcB)));
  assign stall = hit_a || hit_b;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios plus random bundles, checked
// against a queue-based model of scheduled register writes.
module tb_regfile_wb_sched;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  dstE;
  logic [63:0] valE;
  logic [3:0]  dstM;
  logic [63:0] valM;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic        stall;
  logic [15:0] wr_count;
  logic [0:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  regfile_wb_sched dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .srcA(srcA), .srcB(srcB), .stall(stall), .wr_count(wr_count),
    .dbg_state(dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: the write on the port this cycle plus the queue behind it
  typedef struct packed {
    logic [3:0]  a;
    logic [63:0] d;
  } wr_t;

  logic        cur_v = 1'b0;
  wr_t         cur   = '{a: 4'hF, d: 64'h0};
  wr_t         exp_q[$];
  logic [15:0] m_cnt = 16'h0;

  function automatic bit in_pending(input logic [3:0] src);
    bit hit;
    hit = 1'b0;
    if (src != 4'hF) begin
      if (cur_v && cur.a == src) hit = 1'b1;
      foreach (exp_q[i]) if (exp_q[i].a == src) hit = 1'b1;
    end
    return hit;
  endfunction

  task automatic model_edge(output bit acc);
    wr_t lst[$];
    wr_t w;
    acc = 1'b0;
    if (!rst_n) begin
      cur_v = 1'b0;
      cur   = '{a: 4'hF, d: 64'h0};
      exp_q.delete();
      m_cnt = 16'h0;
    end else begin
      if (cur_v) m_cnt = m_cnt + 16'd1;
      cur_v = 1'b0;
      cur   = '{a: 4'hF, d: 64'h0};
      if (exp_q.size() != 0) begin
        w     = exp_q.pop_front();
        cur_v = 1'b1;
        cur   = w;
      end else if (in_valid) begin
        acc = 1'b1;
        if (dstE != 4'hF && dstM != 4'hF && dstE != dstM) begin
          lst.push_back('{a: dstE, d: valE});
          lst.push_back('{a: dstM, d: valM});
        end else if (dstM != 4'hF) lst.push_back('{a: dstM, d: valM});
        else if (dstE != 4'hF) lst.push_back('{a: dstE, d: valE});
        if (lst.size() > 0) begin
          cur_v = 1'b1;
          cur   = lst.pop_front();
        end
        foreach (lst[i]) exp_q.push_back(lst[i]);
      end
    end
  endtask

  // scoreboard comparison
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: combinational checks mid-cycle, model update, registered checks
  task automatic step(output bit acc);
    #1;
    chk("in_ready", {63'h0, in_ready}, {63'h0, rst_n && exp_q.size() == 0});
    chk("stall", {63'h0, stall}, {63'h0, in_pending(srcA) || in_pending(srcB)});
    chk("state", {63'h0, dbg_state}, {63'h0, exp_q.size() != 0});
    @(posedge clk);
    model_edge(acc);
    @(negedge clk);
    chk("wr_en", {63'h0, wr_en}, {63'h0, cur_v});
    chk("wr_addr", {60'h0, wr_addr}, {60'h0, cur.a});
    chk("wr_data", wr_data, cur.d);
    chk("wr_count", {48'h0, wr_count}, {48'h0, m_cnt});
  endtask

  // driver
  task automatic set_b(input logic v, input logic [3:0] e, input logic [63:0] ve,
                       input logic [3:0] m, input logic [63:0] vm);
    in_valid = v; dstE = e; valE = ve; dstM = m; valM = vm;
  endtask

  initial begin
    bit acc;
    rst_n = 1'b0; srcA = 4'hF; srcB = 4'hF;
    set_b(1'b1, 4'h2, 64'h7, 4'hF, 64'h0);
    @(posedge clk);
    @(negedge clk);

    // reset held with in_valid high
    step(acc);
    step(acc);
    chk("rst_ready", {63'h0, in_ready}, 64'h0);
    chk("rst_wr_addr", {60'h0, wr_addr}, 64'hF);
    chk("rst_count", {48'h0, wr_count}, 64'h0);
    rst_n = 1'b1;
    set_b(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
    step(acc);

    // back-to-back single E writes
    set_b(1'b1, 4'h0, 64'h2, 4'hF, 64'h0);
    step(acc);
    chk("e1_addr", {60'h0, wr_addr}, 64'h0);
    chk("e1_data", wr_data, 64'h2);
    set_b(1'b1, 4'h1, 64'h3, 4'hF, 64'h0);
    step(acc);
    chk("e2_addr", {60'h0, wr_addr}, 64'h1);
    chk("e2_data", wr_data, 64'h3);
    set_b(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
    step(acc);
    chk("e_count", {48'h0, wr_count}, 64'h2);

    // popq %rbx: dual destination, srcA=3 watches the hazard
    set_b(1'b1, 4'h4, 64'h108, 4'h3, 64'hABCD);
    step(acc);
    chk("dual_e_addr", {60'h0, wr_addr}, 64'h4);
    set_b(1'b1, 4'h5, 64'h99, 4'hF, 64'h0);
    srcA = 4'h3;
    step(acc);
    chk("dual_acc_n1", {63'h0, acc}, 64'h0);
    chk("dual_m_data", wr_data, 64'hABCD);
    step(acc);
    chk("dual_acc_n2", {63'h0, acc}, 64'h1);
    chk("held_addr", {60'h0, wr_addr}, 64'h5);
    set_b(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
    #1;
    chk("stall_n3", {63'h0, stall}, 64'h0);
    srcA = 4'hF; srcB = 4'h5;
    step(acc);
    srcB = 4'hF;

    // same destination: M wins, single write
    set_b(1'b1, 4'h4, 64'h108, 4'h4, 64'h55);
    step(acc);
    chk("same_data", wr_data, 64'h55);
    set_b(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
    step(acc);
    chk("same_single", {63'h0, wr_en}, 64'h0);

    // reset during HOLD_M drops the parked write
    set_b(1'b1, 4'h6, 64'h11, 4'h7, 64'h22);
    step(acc);
    set_b(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
    rst_n = 1'b0;
    step(acc);
    chk("rst_hold_wr_en", {63'h0, wr_en}, 64'h0);
    rst_n = 1'b1;
    step(acc);
    chk("rst_hold_after", {63'h0, wr_en}, 64'h0);

    // random bundles, held while not accepted
    acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (acc || !in_valid)
        set_b($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), {$urandom, $urandom},
              4'($urandom_range(0, 15)), {$urandom, $urandom});
      srcA = 4'($urandom_range(0, 15));
      srcB = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 60) == 0) rst_n = 1'b0;
      step(acc);
      rst_n = 1'b1;
    end

    // counter wrap after exactly 65536 writes since reset
    set_b(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
    srcA = 4'hF; srcB = 4'hF;
    rst_n = 1'b0;
    step(acc);
    rst_n = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      set_b(1'b1, 4'(i % 15), 64'(i), 4'hF, 64'h0);
      step(acc);
    end
    set_b(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
    step(acc);
    step(acc);
    chk("wrap_count", {48'h0, wr_count}, 64'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
